// File: rtl/reg_file_8x16_if.sv
// Decode / write-back side bundle for the 8x16 register file.
// Read, write-back and reservation channels plus the scoreboard and hazard returns.
interface reg_file_8x16_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic                     rd_en;
  logic [ADDR_W-1:0]        ra_addr;
  logic [ADDR_W-1:0]        rb_addr;
  logic [DATA_W-1:0]        ra_data;
  logic [DATA_W-1:0]        rb_data;
  logic                     rd_valid;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [(1<<ADDR_W)-1:0]   busy;
  logic                     hazard;

  modport slave (
    input  rd_en, ra_addr, rb_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output ra_data, rb_data, rd_valid, busy, hazard
  );

  modport master (
    output rd_en, ra_addr, rb_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  ra_data, rb_data, rd_valid, busy, hazard
  );
endinterface

// File: rtl/reg_file_8x16.sv
// 8x16 register file: two registered read ports, one write port, pending-write scoreboard.
// Read latency 1 clock; no backpressure, hazard is advisory and decode must stall itself.
module reg_file_8x16 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input logic            clk,
  input logic            rst,
  reg_file_8x16_if.slave bus
);
  localparam int N = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [N];
  logic [DATA_W-1:0] r_ra_data;
  logic [DATA_W-1:0] r_rb_data;
  logic              r_rd_valid;
  logic [N-1:0]      r_busy;

  logic [DATA_W-1:0] w_ra_nxt;
  logic [DATA_W-1:0] w_rb_nxt;
  logic              w_wr_a;
  logic              w_wr_b;
  logic              w_pend_a;
  logic              w_pend_b;

  // A same-edge write to a nonzero source wins over storage; R0 always reads zero.
  assign w_wr_a = bus.wr_en && (bus.wr_addr == bus.ra_addr) && (bus.ra_addr != '0);
  assign w_wr_b = bus.wr_en && (bus.wr_addr == bus.rb_addr) && (bus.rb_addr != '0);

  always_comb begin
    w_ra_nxt = '0;
    w_rb_nxt = '0;
    if (w_wr_a)                    w_ra_nxt = bus.wr_data;
    else if (bus.ra_addr != '0)    w_ra_nxt = r_regs[bus.ra_addr];
    if (w_wr_b)                    w_rb_nxt = bus.wr_data;
    else if (bus.rb_addr != '0)    w_rb_nxt = r_regs[bus.rb_addr];
  end

  // A source being written this cycle is covered by the bypass, so it is not pending.
  assign w_pend_a   = (bus.ra_addr != '0) && r_busy[bus.ra_addr] && !w_wr_a;
  assign w_pend_b   = (bus.rb_addr != '0) && r_busy[bus.rb_addr] && !w_wr_b;
  assign bus.hazard = bus.rd_en && (w_pend_a || w_pend_b);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) r_regs[i] <= '0;
    end else if (bus.wr_en && (bus.wr_addr != '0)) begin
      r_regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ra_data  <= '0;
      r_rb_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        r_ra_data <= w_ra_nxt;
        r_rb_data <= w_rb_nxt;
      end
    end
  end

  // A new reservation outranks a retiring write to the same register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      for (int i = 1; i < N; i++) begin
        if (bus.rsv_en && (bus.rsv_addr == ADDR_W'(i)))
          r_busy[i] <= 1'b1;
        else if (bus.wr_en && (bus.wr_addr == ADDR_W'(i)))
          r_busy[i] <= 1'b0;
      end
    end
  end

  assign bus.ra_data  = r_ra_data;
  assign bus.rb_data  = r_rb_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.busy     = r_busy;
endmodule

// File: tb/tb_reg_file_8x16.sv
// Directed bench for reg_file_8x16: reads, R0 rules, bypass, scoreboard, hazard, async reset.
module tb_reg_file_8x16;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  reg_file_8x16_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  reg_file_8x16 #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.rd_en    = 1'b0;
    bus.ra_addr  = 3'd0;
    bus.rb_addr  = 3'd0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = 3'd0;
    bus.wr_data  = 16'h0000;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = 3'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  task automatic rd(input logic [2:0] a, input logic [2:0] b);
    bus.rd_en   = 1'b1;
    bus.ra_addr = a;
    bus.rb_addr = b;
  endtask

  task automatic rsv(input logic [2:0] a);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = a;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    idle();
    #12;
    chk("reset_ra", bus.ra_data, 16'h0000);
    chk("reset_rb", bus.rb_data, 16'h0000);
    chk("reset_valid", {15'd0, bus.rd_valid}, 16'h0000);
    chk("reset_busy", {8'd0, bus.busy}, 16'h0000);
    rst = 1'b1;

    // Basic write then read
    wr(3'd3, 16'h07D8); tick();
    idle(); rd(3'd3, 3'd0); tick();
    chk("read_r3", bus.ra_data, 16'h07D8);
    chk("read_r0_b", bus.rb_data, 16'h0000);
    chk("read_valid", {15'd0, bus.rd_valid}, 16'h0001);
    idle(); tick();
    chk("valid_pulse", {15'd0, bus.rd_valid}, 16'h0000);
    chk("ra_hold", bus.ra_data, 16'h07D8);

    // R0 hardwired, back-to-back writes
    wr(3'd0, 16'h7777); tick();
    idle(); rd(3'd0, 3'd3); tick();
    chk("r0_read", bus.ra_data, 16'h0000);
    chk("r3_port_b", bus.rb_data, 16'h07D8);
    idle(); wr(3'd5, 16'h1245); tick();
    wr(3'd5, 16'h1874); tick();
    idle(); rd(3'd5, 3'd0); tick();
    chk("r5_last_write", bus.ra_data, 16'h1874);

    // Bypass on both ports
    idle(); wr(3'd6, 16'h8745); rd(3'd6, 3'd6); tick();
    chk("bypass_a", bus.ra_data, 16'h8745);
    chk("bypass_b", bus.rb_data, 16'h8745);

    // Reservation of R0 ignored
    idle(); rsv(3'd0); tick();
    chk("rsv_r0_busy", {8'd0, bus.busy}, 16'h0000);

    // Scoreboard on R2
    idle(); rsv(3'd2); tick();
    chk("busy_r2", {8'd0, bus.busy}, 16'h0004);
    idle(); rd(3'd2, 3'd0); #1;
    chk("hazard_r2", {15'd0, bus.hazard}, 16'h0001);
    tick();
    wr(3'd2, 16'h0001); #1;
    chk("hazard_cleared_by_wr", {15'd0, bus.hazard}, 16'h0000);
    tick();
    chk("r2_bypass_capture", bus.ra_data, 16'h0001);
    chk("busy_cleared", {8'd0, bus.busy}, 16'h0000);

    // Simultaneous reservation and write to R4
    idle(); rsv(3'd4); wr(3'd4, 16'h1111); tick();
    chk("busy_r4_kept", {8'd0, bus.busy}, 16'h0010);
    idle(); rd(3'd0, 3'd4); #1;
    chk("hazard_r4_b", {15'd0, bus.hazard}, 16'h0001);
    tick();
    chk("r4_data", bus.rb_data, 16'h1111);
    idle(); bus.ra_addr = 3'd4; #1;
    chk("hazard_needs_rd_en", {15'd0, bus.hazard}, 16'h0000);

    // Same-cycle reservation does not raise hazard
    idle(); rsv(3'd3); rd(3'd3, 3'd0); #1;
    chk("hazard_same_cycle_rsv", {15'd0, bus.hazard}, 16'h0000);
    tick();
    chk("busy_r3_r4", {8'd0, bus.busy}, 16'h0018);

    // Drain, then set up R1=0xABCD with busy=0x02
    idle(); wr(3'd3, 16'h0033); tick();
    wr(3'd4, 16'h0044); tick();
    wr(3'd1, 16'hABCD); tick();
    idle(); rsv(3'd1); rd(3'd1, 3'd0); tick();
    chk("pre_reset_r1", bus.ra_data, 16'hABCD);
    chk("pre_reset_busy", {8'd0, bus.busy}, 16'h0002);

    // Asynchronous reset mid-cycle, during a write to R7
    idle(); wr(3'd7, 16'h5555); #2;
    rst = 1'b0; #1;
    chk("arst_ra", bus.ra_data, 16'h0000);
    chk("arst_valid", {15'd0, bus.rd_valid}, 16'h0000);
    chk("arst_busy", {8'd0, bus.busy}, 16'h0000);
    tick();
    idle(); #1;
    rst = 1'b1;
    rd(3'd1, 3'd7); tick();
    chk("post_reset_r1", bus.ra_data, 16'h0000);
    chk("post_reset_r7_lost", bus.rb_data, 16'h0000);
    chk("post_reset_valid", {15'd0, bus.rd_valid}, 16'h0001);

    idle(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
